// File: rtl/pkt_rx_monitor_pkg.sv
// pkt_rx_monitor_pkg: beat-type codes, head-tag field positions,
// FSM state encoding and the latency clip helper for the rx monitor.
package pkt_rx_monitor_pkg;

   localparam int FLOW_NUM = 8;
   localparam int FLOW_W   = 3;
   localparam int STAT_W   = 32;
   localparam int TS_W     = 48;
   localparam int BEAT_W   = 8;
   localparam int LEN_W    = 12;

   localparam logic [1:0] BT_HEAD = 2'b01;
   localparam logic [1:0] BT_BODY = 2'b11;
   localparam logic [1:0] BT_TAIL = 2'b10;

   localparam int BT_HI  = 133;
   localparam int BT_LO  = 132;
   localparam int INV_HI = 131;
   localparam int INV_LO = 128;

   localparam int TAG_FLOW_HI = 127;
   localparam int TAG_FLOW_LO = 125;
   localparam int TAG_LEN_HI  = 123;
   localparam int TAG_LEN_LO  = 112;
   localparam int TAG_TS_HI   = 47;
   localparam int TAG_TS_LO   = 0;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_BODY       = 2'd1,
      ST_WAIT_VALID = 2'd2
   } rx_state_e;

   // Latency modulo 2^48, clipped to all-ones when it exceeds 32 bits.
   function automatic logic [STAT_W-1:0] lat_clip(
      input logic [TS_W-1:0] now,
      input logic [TS_W-1:0] tx
   );
      logic [TS_W-1:0] d;
      d = now - tx;
      return (|d[TS_W-1:STAT_W]) ? '1 : d[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/pkt_rx_monitor_rx_flow_stat.sv
// rx_flow_stat: per-flow good/error counters and last/max latency.
// Ports: clr (sync clear), upd_* (one verdict per cycle), rd_* (registered read + ack).
module rx_flow_stat #(
   parameter int NFLOW = 8,
   parameter int FW    = 3,
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             upd_en,
   input  logic [FW-1:0]    upd_flow,
   input  logic             upd_good,
   input  logic [CNT_W-1:0] upd_lat,
   input  logic             rd_en,
   input  logic [FW-1:0]    rd_flow,
   output logic [CNT_W-1:0] rd_pkt,
   output logic [CNT_W-1:0] rd_err,
   output logic [CNT_W-1:0] rd_last,
   output logic [CNT_W-1:0] rd_max,
   output logic             rd_ack
);

   logic [NFLOW-1:0][CNT_W-1:0] pkt_cnt;
   logic [NFLOW-1:0][CNT_W-1:0] err_cnt;
   logic [NFLOW-1:0][CNT_W-1:0] last_lat;
   logic [NFLOW-1:0][CNT_W-1:0] max_lat;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Clear wins over a same-cycle verdict, which is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         err_cnt  <= '0;
         last_lat <= '0;
         max_lat  <= '0;
      end else if (clr) begin
         pkt_cnt  <= '0;
         err_cnt  <= '0;
         last_lat <= '0;
         max_lat  <= '0;
      end else if (upd_en) begin
         if (upd_good) begin
            pkt_cnt[upd_flow]  <= sat_inc(pkt_cnt[upd_flow]);
            last_lat[upd_flow] <= upd_lat;
            if (upd_lat > max_lat[upd_flow])
               max_lat[upd_flow] <= upd_lat;
         end else begin
            err_cnt[upd_flow] <= sat_inc(err_cnt[upd_flow]);
         end
      end
   end

   // Read samples the arrays before this cycle's update lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pkt  <= '0;
         rd_err  <= '0;
         rd_last <= '0;
         rd_max  <= '0;
         rd_ack  <= 1'b0;
      end else begin
         rd_ack <= rd_en;
         if (rd_en) begin
            rd_pkt  <= pkt_cnt[rd_flow];
            rd_err  <= err_cnt[rd_flow];
            rd_last <= last_lat[rd_flow];
            rd_max  <= max_lat[rd_flow];
         end
      end
   end

endmodule

// File: rtl/pkt_rx_monitor.sv
// pkt_rx_monitor: checks looped-back test packets and keeps per-flow stats.
// Ports: in_data* packet stream + verdict strobe, in_stat_* read port, out_stat_* / out_orphan_cnt.
module pkt_rx_monitor
   import pkt_rx_monitor_pkg::*;
#(
   parameter string PLATFORM = "xilinx",
   parameter int    FLOW_NUM = pkt_rx_monitor_pkg::FLOW_NUM,
   parameter int    CNT_W    = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cnt_rst,
   input  logic [TS_W-1:0]   timestamp,
   input  logic [133:0]      in_data,
   input  logic              in_data_wr,
   input  logic              in_data_valid,
   input  logic              in_data_valid_wr,
   input  logic              in_stat_rd,
   input  logic [FLOW_W-1:0] in_stat_flow,
   output logic [CNT_W-1:0]  out_stat_pkt_cnt,
   output logic [CNT_W-1:0]  out_stat_err_cnt,
   output logic [CNT_W-1:0]  out_stat_last_lat,
   output logic [CNT_W-1:0]  out_stat_max_lat,
   output logic              out_stat_ack,
   output logic [CNT_W-1:0]  out_orphan_cnt
);

   logic [1:0]        beat;
   logic              is_head;
   logic              is_body;
   logic              is_tail;
   logic              is_cont;

   rx_state_e         state_q;
   rx_state_e         state_d;

   logic [FLOW_W-1:0] flow_q;
   logic [LEN_W-1:0]  exp_len_q;
   logic [TS_W-1:0]   tx_ts_q;
   logic [BEAT_W-1:0] beats_q;
   logic [BEAT_W-1:0] beats_inc;
   logic [LEN_W-1:0]  pkt_len;
   logic              len_ok_now;
   logic              len_ok_q;

   logic              head_load;
   logic              beat_step;
   logic              tail_cap;
   logic              orphan_inc;
   logic              upd_en;
   logic              upd_good;
   logic [CNT_W-1:0]  upd_lat;
   logic [CNT_W-1:0]  orphan_q;
   logic              unused_bits;

   assign beat    = in_data[BT_HI:BT_LO];
   assign is_head = in_data_wr && (beat == BT_HEAD);
   assign is_body = in_data_wr && (beat == BT_BODY);
   assign is_tail = in_data_wr && (beat == BT_TAIL);
   assign is_cont = is_body || is_tail;

   assign unused_bits = ^{in_data[124], in_data[111:48]};

   // Beat count saturates at 255; a saturated packet never matches.
   assign beats_inc  = (&beats_q) ? beats_q : beats_q + 8'd1;
   assign pkt_len    = {beats_inc, 4'h0}
                     - LEN_W'(in_data[INV_HI:INV_LO]);
   assign len_ok_now = !(&beats_inc) && (pkt_len == exp_len_q);

   assign upd_lat = lat_clip(timestamp, tx_ts_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (is_head)
               state_d = ST_BODY;
         end
         ST_BODY: begin
            if (is_head)
               state_d = ST_BODY;
            else if (is_tail)
               state_d = in_data_valid_wr ? ST_IDLE : ST_WAIT_VALID;
            else if (in_data_valid_wr)
               state_d = ST_IDLE;
         end
         ST_WAIT_VALID: begin
            if (is_head)
               state_d = ST_BODY;
            else if (in_data_valid_wr)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Verdict and datapath controls; verdicts always hit the latched flow.
   always_comb begin
      head_load  = 1'b0;
      beat_step  = 1'b0;
      tail_cap   = 1'b0;
      orphan_inc = 1'b0;
      upd_en     = 1'b0;
      upd_good   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            head_load  = is_head;
            orphan_inc = is_cont;
         end
         ST_BODY: begin
            if (is_head) begin
               upd_en    = 1'b1;
               head_load = 1'b1;
            end else if (is_body) begin
               beat_step = 1'b1;
            end else if (is_tail) begin
               beat_step = 1'b1;
               tail_cap  = 1'b1;
               if (in_data_valid_wr) begin
                  upd_en   = 1'b1;
                  upd_good = in_data_valid && len_ok_now;
               end
            end else if (in_data_valid_wr) begin
               // Strobe before any tail: packet is short.
               upd_en = 1'b1;
            end
         end
         ST_WAIT_VALID: begin
            if (in_data_valid_wr) begin
               upd_en    = 1'b1;
               upd_good  = in_data_valid && len_ok_q;
               head_load = is_head;
            end else if (is_head) begin
               upd_en    = 1'b1;
               head_load = 1'b1;
            end else begin
               orphan_inc = is_cont;
            end
         end
         default: begin
            head_load = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flow_q    <= '0;
         exp_len_q <= '0;
         tx_ts_q   <= '0;
         beats_q   <= '0;
         len_ok_q  <= 1'b0;
      end else if (head_load) begin
         flow_q    <= in_data[TAG_FLOW_HI:TAG_FLOW_LO];
         exp_len_q <= in_data[TAG_LEN_HI:TAG_LEN_LO];
         tx_ts_q   <= in_data[TAG_TS_HI:TAG_TS_LO];
         beats_q   <= 8'd1;
         len_ok_q  <= 1'b0;
      end else begin
         if (beat_step)
            beats_q <= beats_inc;
         if (tail_cap)
            len_ok_q <= len_ok_now;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         orphan_q <= '0;
      else if (cnt_rst)
         orphan_q <= '0;
      else if (orphan_inc && !(&orphan_q))
         orphan_q <= orphan_q + CNT_W'(1);
   end

   assign out_orphan_cnt = orphan_q;

   rx_flow_stat #(
      .NFLOW (FLOW_NUM),
      .FW    (FLOW_W),
      .CNT_W (CNT_W)
   ) u_stat (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_rst),
      .upd_en   (upd_en),
      .upd_flow (flow_q),
      .upd_good (upd_good),
      .upd_lat  (upd_lat),
      .rd_en    (in_stat_rd),
      .rd_flow  (in_stat_flow),
      .rd_pkt   (out_stat_pkt_cnt),
      .rd_err   (out_stat_err_cnt),
      .rd_last  (out_stat_last_lat),
      .rd_max   (out_stat_max_lat),
      .rd_ack   (out_stat_ack)
   );

endmodule

// File: tb/tb_pkt_rx_monitor.sv
// tb_pkt_rx_monitor: directed scenario bench for pkt_rx_monitor.
// Each task drives one scenario and checks stats against hand values.
module tb_pkt_rx_monitor;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cnt_rst = 1'b0;
   logic [47:0]  timestamp = '0;
   logic [133:0] in_data = '0;
   logic         in_data_wr = 1'b0;
   logic         in_data_valid = 1'b0;
   logic         in_data_valid_wr = 1'b0;
   logic         in_stat_rd = 1'b0;
   logic [2:0]   in_stat_flow = '0;
   logic [31:0]  out_stat_pkt_cnt;
   logic [31:0]  out_stat_err_cnt;
   logic [31:0]  out_stat_last_lat;
   logic [31:0]  out_stat_max_lat;
   logic         out_stat_ack;
   logic [31:0]  out_orphan_cnt;

   logic [127:0] st;
   int total = 0;
   int bad = 0;

   localparam logic [133:0] BODY_B = {2'b11, 132'h0};

   always #5 clk = ~clk;

   assign st = {out_stat_pkt_cnt, out_stat_err_cnt,
                out_stat_last_lat, out_stat_max_lat};

   pkt_rx_monitor dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cnt_rst           (cnt_rst),
      .timestamp         (timestamp),
      .in_data           (in_data),
      .in_data_wr        (in_data_wr),
      .in_data_valid     (in_data_valid),
      .in_data_valid_wr  (in_data_valid_wr),
      .in_stat_rd        (in_stat_rd),
      .in_stat_flow      (in_stat_flow),
      .out_stat_pkt_cnt  (out_stat_pkt_cnt),
      .out_stat_err_cnt  (out_stat_err_cnt),
      .out_stat_last_lat (out_stat_last_lat),
      .out_stat_max_lat  (out_stat_max_lat),
      .out_stat_ack      (out_stat_ack),
      .out_orphan_cnt    (out_orphan_cnt)
   );

   function automatic logic [133:0] head(
      input logic [2:0]  f,
      input logic [11:0] len,
      input logic [47:0] tx
   );
      return {2'b01, 4'h0, f, 1'b0, len, 64'h0, tx};
   endfunction

   function automatic logic [133:0] tail(input logic [3:0] inv);
      return {2'b10, inv, 128'h0};
   endfunction

   task automatic do_cnt_rst();
      @(negedge clk); cnt_rst = 1'b1;
      @(negedge clk); cnt_rst = 1'b0;
   endtask

   task automatic rd(input logic [2:0] f);
      @(negedge clk); in_stat_rd = 1'b1; in_stat_flow = f;
      @(negedge clk); in_stat_rd = 1'b0;
   endtask

   // Head, nb-2 bodies, tail; strobe in tail cycle when same=1.
   task automatic send_pkt(
      input logic [2:0]  f,
      input logic [11:0] len,
      input logic [47:0] tx,
      input int          nb,
      input logic [3:0]  inv,
      input logic [47:0] ts,
      input logic        vld,
      input bit          same,
      input bit          clr_at,
      input bit          rd_at
   );
      @(negedge clk); in_data_wr = 1'b1; in_data = head(f, len, tx);
      for (int i = 1; i < nb - 1; i++) begin
         @(negedge clk); in_data = BODY_B;
      end
      @(negedge clk); in_data = tail(inv);
      if (!same) begin
         @(negedge clk); in_data_wr = 1'b0; in_data = '0;
      end
      in_data_valid_wr = 1'b1;
      in_data_valid    = vld;
      timestamp        = ts;
      cnt_rst          = clr_at;
      in_stat_rd       = rd_at;
      in_stat_flow     = f;
      @(negedge clk);
      in_data_wr       = 1'b0;
      in_data          = '0;
      in_data_valid_wr = 1'b0;
      in_data_valid    = 1'b0;
      cnt_rst          = 1'b0;
      in_stat_rd       = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (st !== 128'h0 || out_stat_ack !== 1'b0) begin
         bad++;
         $display("FAIL reset_out got=%h ack=%b want 0", st, out_stat_ack);
      end
      total++;
      if (out_orphan_cnt !== 32'd0) begin
         bad++;
         $display("FAIL reset_orphan got=%h want 0", out_orphan_cnt);
      end
      rd(3'd0);
      total++;
      if (out_stat_ack !== 1'b1 || st !== 128'h0) begin
         bad++;
         $display("FAIL reset_rd ack=%b got=%h want 1/0", out_stat_ack, st);
      end
      @(negedge clk);
      total++;
      if (out_stat_ack !== 1'b0) begin
         bad++;
         $display("FAIL ack_pulse got=%b want 0", out_stat_ack);
      end
   endtask

   task automatic test_good();
      send_pkt(3'd3, 12'd64, 48'd1000, 4, 4'd0, 48'd1500, 1'b1, 0, 0, 0);
      rd(3'd3);
      total++;
      if (out_stat_ack !== 1'b1 ||
          st !== {32'd1, 32'd0, 32'd500, 32'd500}) begin
         bad++;
         $display("FAIL good ack=%b got=%h want 1/%h", out_stat_ack, st,
                  {32'd1, 32'd0, 32'd500, 32'd500});
      end
      send_pkt(3'd3, 12'd60, 48'd2000, 4, 4'd4, 48'd2200, 1'b1, 1, 0, 0);
      rd(3'd3);
      total++;
      if (st !== {32'd2, 32'd0, 32'd200, 32'd500}) begin
         bad++;
         $display("FAIL good_inv got=%h want %h", st,
                  {32'd2, 32'd0, 32'd200, 32'd500});
      end
   endtask

   task automatic test_len_err();
      do_cnt_rst();
      send_pkt(3'd3, 12'd60, 48'd1000, 4, 4'd0, 48'd1500, 1'b1, 0, 0, 0);
      rd(3'd3);
      total++;
      if (st !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
         bad++;
         $display("FAIL len_err got=%h want %h", st,
                  {32'd0, 32'd1, 32'd0, 32'd0});
      end
      do_cnt_rst();
      send_pkt(3'd3, 12'd64, 48'd1000, 4, 4'd0, 48'd1500, 1'b0, 0, 0, 0);
      rd(3'd3);
      total++;
      if (st !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
         bad++;
         $display("FAIL crc_err got=%h want %h", st,
                  {32'd0, 32'd1, 32'd0, 32'd0});
      end
   endtask

   task automatic test_latency();
      do_cnt_rst();
      send_pkt(3'd1, 12'd32, 48'hFFFF_FFFF_FF00, 2, 4'd0, 48'h40,
               1'b1, 0, 0, 0);
      rd(3'd1);
      total++;
      if (st !== {32'd1, 32'd0, 32'h140, 32'h140}) begin
         bad++;
         $display("FAIL lat_wrap got=%h want %h", st,
                  {32'd1, 32'd0, 32'h140, 32'h140});
      end
      send_pkt(3'd1, 12'd32, 48'd0, 2, 4'd0, 48'h2_0000_0000,
               1'b1, 0, 0, 0);
      rd(3'd1);
      total++;
      if (st !== {32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
         bad++;
         $display("FAIL lat_clip got=%h want %h", st,
                  {32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      end
      send_pkt(3'd1, 12'd32, 48'd100, 2, 4'd0, 48'd110, 1'b1, 0, 0, 0);
      rd(3'd1);
      total++;
      if (st !== {32'd3, 32'd0, 32'd10, 32'hFFFF_FFFF}) begin
         bad++;
         $display("FAIL lat_max_hold got=%h want %h", st,
                  {32'd3, 32'd0, 32'd10, 32'hFFFF_FFFF});
      end
   endtask

   task automatic test_restart();
      do_cnt_rst();
      @(negedge clk); in_data_wr = 1'b1; in_data = head(3'd2, 12'd64, 48'd0);
      @(negedge clk); in_data = BODY_B;
      @(negedge clk); in_data = head(3'd5, 12'd32, 48'd10);
      @(negedge clk); in_data = tail(4'd0);
      @(negedge clk); in_data_wr = 1'b0; in_data = '0;
      in_data_valid_wr = 1'b1; in_data_valid = 1'b1; timestamp = 48'd60;
      @(negedge clk); in_data_valid_wr = 1'b0; in_data_valid = 1'b0;
      rd(3'd2);
      total++;
      if (st !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
         bad++;
         $display("FAIL restart_old got=%h want %h", st,
                  {32'd0, 32'd1, 32'd0, 32'd0});
      end
      rd(3'd5);
      total++;
      if (st !== {32'd1, 32'd0, 32'd50, 32'd50}) begin
         bad++;
         $display("FAIL restart_new got=%h want %h", st,
                  {32'd1, 32'd0, 32'd50, 32'd50});
      end
      @(negedge clk); in_data_wr = 1'b1; in_data = head(3'd1, 12'd32, 48'd0);
      @(negedge clk); in_data = tail(4'd0);
      @(negedge clk); in_data = head(3'd1, 12'd32, 48'd0);
      @(negedge clk); in_data = tail(4'd0);
      @(negedge clk); in_data_wr = 1'b0; in_data = '0;
      in_data_valid_wr = 1'b1; in_data_valid = 1'b1; timestamp = 48'd40;
      @(negedge clk); in_data_valid_wr = 1'b0; in_data_valid = 1'b0;
      rd(3'd1);
      total++;
      if (st !== {32'd1, 32'd1, 32'd40, 32'd40}) begin
         bad++;
         $display("FAIL wait_head got=%h want %h", st,
                  {32'd1, 32'd1, 32'd40, 32'd40});
      end
   endtask

   task automatic test_orphan();
      do_cnt_rst();
      @(negedge clk); in_data_wr = 1'b1; in_data = tail(4'd0);
      @(negedge clk); in_data_wr = 1'b0; in_data = '0;
      total++;
      if (out_orphan_cnt !== 32'd1) begin
         bad++;
         $display("FAIL orphan got=%0d want 1", out_orphan_cnt);
      end
      rd(3'd3);
      total++;
      if (st !== 128'h0) begin
         bad++;
         $display("FAIL orphan_flow got=%h want 0", st);
      end
   endtask

   task automatic test_saturate();
      logic [7:0][31:0] pre;
      do_cnt_rst();
      pre = '0;
      pre[3] = 32'hFFFF_FFFE;
      @(negedge clk); force dut.u_stat.pkt_cnt = pre;
      @(negedge clk); release dut.u_stat.pkt_cnt;
      for (int i = 0; i < 3; i++)
         send_pkt(3'd3, 12'd32, 48'd0, 2, 4'd0, 48'd7, 1'b1, 0, 0, 0);
      rd(3'd3);
      total++;
      if (st !== {32'hFFFF_FFFF, 32'd0, 32'd7, 32'd7}) begin
         bad++;
         $display("FAIL saturate got=%h want %h", st,
                  {32'hFFFF_FFFF, 32'd0, 32'd7, 32'd7});
      end
   endtask

   task automatic test_clr_verdict();
      do_cnt_rst();
      send_pkt(3'd3, 12'd32, 48'd0, 2, 4'd0, 48'd20, 1'b1, 0, 0, 0);
      rd(3'd3);
      total++;
      if (st !== {32'd1, 32'd0, 32'd20, 32'd20}) begin
         bad++;
         $display("FAIL clr_pre got=%h want %h", st,
                  {32'd1, 32'd0, 32'd20, 32'd20});
      end
      send_pkt(3'd3, 12'd32, 48'd0, 2, 4'd0, 48'd30, 1'b1, 1, 1, 0);
      rd(3'd3);
      total++;
      if (st !== 128'h0) begin
         bad++;
         $display("FAIL clr_verdict got=%h want 0", st);
      end
   endtask

   task automatic test_back_to_back();
      do_cnt_rst();
      send_pkt(3'd4, 12'd32, 48'd0, 2, 4'd0, 48'd100, 1'b1, 0, 0, 0);
      send_pkt(3'd4, 12'd32, 48'd0, 2, 4'd0, 48'd300, 1'b1, 0, 0, 1);
      total++;
      if (out_stat_ack !== 1'b1 ||
          st !== {32'd1, 32'd0, 32'd100, 32'd100}) begin
         bad++;
         $display("FAIL rd_same_cycle ack=%b got=%h want 1/%h",
                  out_stat_ack, st, {32'd1, 32'd0, 32'd100, 32'd100});
      end
      rd(3'd4);
      total++;
      if (st !== {32'd2, 32'd0, 32'd300, 32'd300}) begin
         bad++;
         $display("FAIL rd_after got=%h want %h", st,
                  {32'd2, 32'd0, 32'd300, 32'd300});
      end
   endtask

   task automatic test_reset_mid();
      do_cnt_rst();
      send_pkt(3'd3, 12'd32, 48'd0, 2, 4'd0, 48'd9, 1'b1, 0, 0, 0);
      rd(3'd3);
      total++;
      if (st !== {32'd1, 32'd0, 32'd9, 32'd9}) begin
         bad++;
         $display("FAIL mid_pre got=%h want %h", st,
                  {32'd1, 32'd0, 32'd9, 32'd9});
      end
      @(negedge clk); in_data_wr = 1'b1; in_data = head(3'd6, 12'd64, 48'd0);
      @(negedge clk); in_data = BODY_B;
      @(negedge clk); in_data_wr = 1'b0; in_data = '0; rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      total++;
      if (st !== 128'h0 || out_stat_ack !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_out got=%h ack=%b want 0", st, out_stat_ack);
      end
      @(negedge clk); in_data_wr = 1'b1; in_data = BODY_B;
      @(negedge clk); in_data = tail(4'd0);
      @(negedge clk); in_data_wr = 1'b0; in_data = '0;
      total++;
      if (out_orphan_cnt !== 32'd2) begin
         bad++;
         $display("FAIL mid_orphan got=%0d want 2", out_orphan_cnt);
      end
      rd(3'd6);
      total++;
      if (st !== 128'h0) begin
         bad++;
         $display("FAIL mid_flow got=%h want 0", st);
      end
      send_pkt(3'd6, 12'd32, 48'd0, 2, 4'd0, 48'd5, 1'b1, 0, 0, 0);
      rd(3'd6);
      total++;
      if (st !== {32'd1, 32'd0, 32'd5, 32'd5}) begin
         bad++;
         $display("FAIL mid_after got=%h want %h", st,
                  {32'd1, 32'd0, 32'd5, 32'd5});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_good();
      test_len_err();
      test_latency();
      test_restart();
      test_orphan();
      test_saturate();
      test_clr_verdict();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
